// File: rtl/hex_scan_driver.sv
// Multiplexed hex display scanner: steps through DIGITS digit slots, decodes a
// frame-stable shadow of the input value, and PWM-gates the digit anodes.
module hex_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     anodes,
    output logic [6:0]            segments,
    output logic                  dp_out,
    output logic                  frame
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_dp;

    logic                tc;
    logic                wrap;
    logic                enable;
    logic [3:0]          nib;
    logic                dig_dp;
    logic                blank_hit;
    logic                all_zero;
    logic [DIGITS-1:0]   onehot;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h7E;
            4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;
            4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;
            4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;
            4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E;
            4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;
            4'hF: hex7 = 7'h47;
            default: hex7 = 7'h00;
        endcase
    endfunction

    assign tc     = (presc == PRESC_TC);
    assign wrap   = tc && (idx == IDX_LAST);
    assign enable = (pwm_cnt < brightness) || (&brightness);

    // Walk from the top digit down so all_zero means "this nibble and every one above it is zero".
    always_comb begin
        nib       = 4'h0;
        dig_dp    = 1'b0;
        blank_hit = 1'b0;
        all_zero  = 1'b1;
        onehot    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (shadow_data[4*i +: 4] == 4'h0);
            onehot[i] = (idx == IW'(i));
            if (idx == IW'(i)) begin
                nib       = shadow_data[4*i +: 4];
                dig_dp    = shadow_dp[i];
                blank_hit = all_zero && (i != 0);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc       <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            anodes      <= '0;
            segments    <= '0;
            dp_out      <= 1'b0;
            frame       <= 1'b0;
        end else begin
            presc   <= tc ? '0 : presc + PW'(1);
            pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
            if (tc) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
            // Shadow swaps together with the index returning to 0, so a frame never mixes values.
            if (wrap) begin
                shadow_data <= data;
                shadow_dp   <= dp;
            end
            frame    <= wrap;
            anodes   <= enable ? onehot : '0;
            segments <= (blank_lz && blank_hit) ? 7'h00 : hex7(nib);
            dp_out   <= dig_dp;
        end
    end

endmodule
